fwd_sel_tracker: RTL and testbench
==================================

Name: fwd_sel_tracker

Overview:
- Sequential hazard tracker that generates the 2-bit operand-select codes for the two EX-stage 4:1 operand muxes (rs1 path and rs2 path), and the load-use stall request.
- Sits upstream of those muxes.
- Keeps its own shadow copy of destination-register info for the EX, MEM and WB pipeline slots.
- Computes each select in the ID cycle and registers it, so the code is stable for the whole cycle the consuming instruction spends in EX.

Parameters:
- REG_ADDR_W, 5, register-index width.
- CNT_W, 16, width of the saturating load-use stall counter.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- id_valid  in  1  ID holds a real instruction.
- id_rs1  in  REG_ADDR_W  source 1 index of ID instruction.
- id_rs2  in  REG_ADDR_W  source 2 index of ID instruction.
- id_rd  in  REG_ADDR_W  destination index of ID instruction.
- id_reg_write  in  1  ID instruction writes rd.
- id_mem_read  in  1  ID instruction is a load.
- stall_in  in  1  external freeze (memory wait); all state holds.
- flush  in  1  kill the ID instruction (branch taken); it enters EX as a bubble.
- fwd_a_sel  out  2  select for the rs1 operand mux.
- fwd_b_sel  out  2  select for the rs2 operand mux.
- load_use_stall  out  1  combinational; hold PC and IF/ID, insert a bubble.
- stall_cnt  out  CNT_W  number of load-use stall cycles, saturating.

Behaviour:
- Select encoding, per operand:
  - 00 = register-file value.
  - 01 = EX/MEM ALU result.
  - 10 = MEM/WB writeback value.
  - 11 = retired-write latch, one stage older than WB.
- Internal slots ex_, mem_, wb_ each hold {valid, rd, reg_write, mem_read}.
- A slot "writes r" when valid & reg_write & rd==r & rd!=0.
- Reset (rstn=0, asynchronous): all slot valid bits = 0; fwd_a_sel = fwd_b_sel = 00; stall_cnt = 0. load_use_stall evaluates to 0 because all slots are invalid.
- load_use_stall = id_valid & ex_valid & ex_mem_read & ex_reg_write & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
  - Independent of stall_in and flush.
  - Both sources are checked even when the ID instruction does not use rs2. The decoder zeroes unused indices, and x0 never matches.
- Select computation for operand rs (rs1 or rs2), evaluated in ID. Priority is newest first:
  - ex_ slot writes rs -> 01 (the instruction will be in MEM when the ID instruction reaches EX).
  - else mem_ slot writes rs -> 10.
  - else wb_ slot writes rs -> 11.
  - else 00.
  - rs==0 always gives 00.
- Advance rule on each rising clk edge:
  - If stall_in=1: every slot and both sel registers hold; stall_cnt holds. stall_in overrides flush and load_use_stall.
  - Else: wb_ <= mem_; mem_ <= ex_.
    - If flush or load_use_stall or !id_valid: ex_ <= bubble (valid=0) and fwd_a_sel/fwd_b_sel <= 00.
    - Else: ex_ <= {1, id_rd, id_reg_write, id_mem_read} and the sel registers <= computed codes.
  - stall_cnt increments when load_use_stall=1 and stall_in=0, and saturates at all-ones (no wrap).
- Latency:
  - Selects are registered, one cycle after ID evaluation, and aligned with the EX cycle.
  - load_use_stall has zero latency.
  - Load-use costs exactly one bubble. After it, the load is in mem_ and the dependent instruction's select becomes 10.
- Simultaneous flush and load_use_stall (stall_in=0): a bubble is inserted; stall_cnt still increments.
- Reset asserted mid-operation: takes effect immediately, with no partial-state requirement on the following edge.

Test Plan:
- Reset: rstn=0 with random inputs -> sel=00/00, load_use_stall=0, stall_cnt=0.
- Back-to-back ALU dependency: I0 writes x5 (reg_write=1), next cycle I1 rs1=5, rs2=6 -> I1's EX cycle shows fwd_a_sel=01, fwd_b_sel=00.
- Distance-2 and distance-3 dependencies: x7 written by I0, one unrelated instruction, then I2 rs2=7 -> fwd_b_sel=10. With two unrelated instructions, I3 rs1=7 -> fwd_a_sel=11. With I0 and I1 both writing x7, I2 rs1=7 -> 01 (newest wins).
- Load-use: load x9, then I1 rs1=9 -> load_use_stall=1 for exactly one cycle, stall_cnt=1. Next cycle, I1 held in ID shows load_use_stall=0; its EX cycle shows fwd_a_sel=10.
- x0 and flush: writer of x0 followed by rs1=0 -> sel 00. Flush on I1 that writes x4, then I2 rs1=4 -> sel 00 (bubble not forwarded).
- Freeze and saturation: stall_in=1 for 3 cycles in the middle of the load-use case -> sel, slots and stall_cnt all hold, with normal resumption afterwards. With CNT_W=2 and 5 stalls -> stall_cnt=3.

Source files
------------

// File: rtl/fwd_sel_tracker.sv
// fwd_sel_tracker
//
// Generates the operand-select codes for the two EX-stage 4:1 operand muxes
// and the load-use stall request. The block keeps a shadow copy of the
// destination-register info held by the EX, MEM and WB pipeline slots. It
// computes each select while the consumer sits in ID, then registers it, so
// the code is stable for the whole cycle the consumer spends in EX.
//
// Select encoding (per operand):
//   00 register file, 01 EX/MEM ALU result, 10 MEM/WB writeback value,
//   11 retired-write latch (one stage older than WB).
//
// Ports:
//   clk, rstn        rising-edge clock, asynchronous active-low reset
//   id_valid         ID holds a real instruction
//   id_rs1, id_rs2   source indices of the ID instruction (unused ones are 0)
//   id_rd            destination index of the ID instruction
//   id_reg_write     ID instruction writes rd
//   id_mem_read      ID instruction is a load
//   stall_in         external freeze: every register holds
//   flush            kill the ID instruction; it enters EX as a bubble
//   fwd_a_sel        registered select for the rs1 operand mux
//   fwd_b_sel        registered select for the rs2 operand mux
//   load_use_stall   combinational: hold PC and IF/ID, insert a bubble
//   stall_cnt        saturating count of load-use stall cycles
//
// Flow control: the ID instruction advances into EX on a rising edge only
// when stall_in=0. If id_valid=0, flush=1 or load_use_stall=1 on that edge,
// EX receives a bubble instead. stall_in=1 holds every slot, both selects
// and the counter, whatever the other inputs are.
module fwd_sel_tracker #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  stall_in,
  input  logic                  flush,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  load_use_stall,
  output logic [CNT_W-1:0]      stall_cnt
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
  } slot_t;

  slot_t ex_s, mem_s, wb_s;
  slot_t id_s;
  // Only the EX slot can cause a load-use hazard, so the load flag is kept
  // for that slot alone; older slots forward normally whatever they were.
  logic  ex_mem_read;

  logic [1:0] sel_a_d, sel_b_d;
  logic       inject_bubble;

  function automatic logic writes_reg(input slot_t s,
                                      input logic [REG_ADDR_W-1:0] r);
    return s.valid && s.reg_write && (s.rd == r) && (s.rd != '0);
  endfunction

  // Newest producer wins. The EX slot is one stage ahead, so by the time the
  // consumer reaches EX that producer sits in MEM (code 01), and so on.
  function automatic logic [1:0] pick_sel(input slot_t ex,
                                          input slot_t mem,
                                          input slot_t wb,
                                          input logic [REG_ADDR_W-1:0] rs);
    logic [1:0] sel;
    sel = 2'b00;
    if (writes_reg(ex, rs))       sel = 2'b01;
    else if (writes_reg(mem, rs)) sel = 2'b10;
    else if (writes_reg(wb, rs))  sel = 2'b11;
    return sel;
  endfunction

  always_comb begin
    load_use_stall = 1'b0;
    inject_bubble  = 1'b0;
    sel_a_d        = 2'b00;
    sel_b_d        = 2'b00;
    id_s           = '0;

    // Both sources are checked unconditionally. Unused indices arrive as
    // x0, and x0 never matches because of the rd!=0 term.
    load_use_stall = id_valid && ex_s.valid && ex_mem_read && ex_s.reg_write &&
                     (ex_s.rd != '0) &&
                     ((ex_s.rd == id_rs1) || (ex_s.rd == id_rs2));
    inject_bubble  = flush || load_use_stall || !id_valid;

    sel_a_d = pick_sel(ex_s, mem_s, wb_s, id_rs1);
    sel_b_d = pick_sel(ex_s, mem_s, wb_s, id_rs2);
    id_s    = {1'b1, id_rd, id_reg_write};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_s        <= '0;
      mem_s       <= '0;
      wb_s        <= '0;
      ex_mem_read <= 1'b0;
      fwd_a_sel   <= 2'b00;
      fwd_b_sel   <= 2'b00;
      stall_cnt   <= '0;
    end else if (!stall_in) begin
      wb_s  <= mem_s;
      mem_s <= ex_s;
      if (inject_bubble) begin
        ex_s        <= '0;
        ex_mem_read <= 1'b0;
        fwd_a_sel   <= 2'b00;
        fwd_b_sel   <= 2'b00;
      end else begin
        ex_s        <= id_s;
        ex_mem_read <= id_mem_read;
        fwd_a_sel   <= sel_a_d;
        fwd_b_sel   <= sel_b_d;
      end
      // Saturate rather than wrap, so a long run never looks like a short one.
      if (load_use_stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fwd_sel_tracker.sv
// tb_fwd_sel_tracker
//
// Drives fwd_sel_tracker with directed hazard scenarios followed by random
// instruction streams. A reference model keeps the last three instructions
// that entered EX as a newest-first history. Each cycle's expected outputs
// are queued at drive time and popped by an independent monitor on the
// falling edge. A second instance with a 2-bit counter covers saturation.
module tb_fwd_sel_tracker;

  localparam int W = 23;  // {lus, sel_a, sel_b, cnt[15:0], cnt_small[1:0]}

  // ---------------- clock / reset ----------------
  logic clk;
  logic t_rstn;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT wiring ----------------
  logic       t_valid, t_rw, t_mr, t_st, t_fl;
  logic [4:0] t_rs1, t_rs2, t_rd;
  logic [1:0] a_sel, b_sel, a_sel_s, b_sel_s;
  logic       lus, lus_s;
  logic [15:0] cnt;
  logic [1:0]  cnt_s;

  fwd_sel_tracker #(.REG_ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .rstn(t_rstn), .id_valid(t_valid), .id_rs1(t_rs1),
    .id_rs2(t_rs2), .id_rd(t_rd), .id_reg_write(t_rw), .id_mem_read(t_mr),
    .stall_in(t_st), .flush(t_fl), .fwd_a_sel(a_sel), .fwd_b_sel(b_sel),
    .load_use_stall(lus), .stall_cnt(cnt)
  );

  fwd_sel_tracker #(.REG_ADDR_W(5), .CNT_W(2)) dut_small (
    .clk(clk), .rstn(t_rstn), .id_valid(t_valid), .id_rs1(t_rs1),
    .id_rs2(t_rs2), .id_rd(t_rd), .id_reg_write(t_rw), .id_mem_read(t_mr),
    .stall_in(t_st), .flush(t_fl), .fwd_a_sel(a_sel_s), .fwd_b_sel(b_sel_s),
    .load_use_stall(lus_s), .stall_cnt(cnt_s)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit       valid;
    bit [4:0] rd;
    bit       rw;
    bit       mr;
  } ent_t;

  ent_t     hist[$];   // newest first: [0]=EX, [1]=MEM, [2]=WB
  bit [1:0] m_sel_a, m_sel_b;
  int       m_cnt, m_cnt2;

  function automatic bit ent_writes(input ent_t e, input bit [4:0] r);
    return e.valid && e.rw && (e.rd == r) && (e.rd != 5'd0);
  endfunction

  // Select code is simply (distance of newest producer) + 1, or 0 if none.
  function automatic bit [1:0] model_sel(input bit [4:0] rs);
    for (int d = 0; d < 3; d++) begin
      if (ent_writes(hist[d], rs)) return 2'(d + 1);
    end
    return 2'b00;
  endfunction

  function automatic bit model_lus();
    ent_t e;
    e = hist[0];
    return t_valid && e.valid && e.mr && e.rw && (e.rd != 5'd0) &&
           ((e.rd == t_rs1) || (e.rd == t_rs2));
  endfunction

  function automatic void model_reset();
    ent_t b;
    b = '{1'b0, 5'd0, 1'b0, 1'b0};
    hist.delete();
    for (int i = 0; i < 3; i++) hist.push_back(b);
    m_sel_a = 2'b00;
    m_sel_b = 2'b00;
    m_cnt   = 0;
    m_cnt2  = 0;
  endfunction

  function automatic void model_advance();
    bit       hz;
    bit [1:0] na, nb;
    ent_t     ne;
    if (t_st) return;
    hz = model_lus();
    na = model_sel(t_rs1);
    nb = model_sel(t_rs2);
    if (t_fl || hz || !t_valid) begin
      ne = '{1'b0, 5'd0, 1'b0, 1'b0};
      m_sel_a = 2'b00;
      m_sel_b = 2'b00;
    end else begin
      ne = '{1'b1, t_rd, t_rw, t_mr};
      m_sel_a = na;
      m_sel_b = nb;
    end
    hist.push_front(ne);
    void'(hist.pop_back());
    if (hz) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a rising edge: apply inputs, queue what the DUT must
  // present for the rest of this cycle.
  task automatic drive(input bit v, input bit [4:0] rs1, input bit [4:0] rs2,
                       input bit [4:0] rd, input bit rw, input bit mr,
                       input bit st, input bit fl);
    logic [W-1:0] e;
    t_valid = v; t_rs1 = rs1; t_rs2 = rs2; t_rd = rd;
    t_rw = rw; t_mr = mr; t_st = st; t_fl = fl;
    #1;
    e = {model_lus(), m_sel_a, m_sel_b, m_cnt[15:0], m_cnt2[1:0]};
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic issue(input bit v, input bit [4:0] rs1, input bit [4:0] rs2,
                       input bit [4:0] rd, input bit rw, input bit mr,
                       input bit st, input bit fl);
    drive(v, rs1, rs2, rd, rw, mr, st, fl);
    step();
  endtask

  task automatic set_idle();
    t_valid = 1'b0; t_rs1 = 5'd0; t_rs2 = 5'd0; t_rd = 5'd0;
    t_rw = 1'b0; t_mr = 1'b0; t_st = 1'b0; t_fl = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a_sel"}, a_sel, 2'b00);
    check({tag, "_b_sel"}, b_sel, 2'b00);
    check({tag, "_lus"}, lus, 1'b0);
    check({tag, "_cnt"}, cnt, 16'd0);
    check({tag, "_cnt_small"}, cnt_s, 2'd0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (t_rstn === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("mon_lus", lus, e[22]);
        check("mon_a_sel", a_sel, e[21:20]);
        check("mon_b_sel", b_sel, e[19:18]);
        check("mon_cnt", cnt, e[17:2]);
        check("mon_cnt_small", cnt_s, e[1:0]);
        check("mon_a_sel_small", a_sel_s, e[21:20]);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset with random inputs: outputs must be cleared regardless.
    t_rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      t_valid = 1'($urandom_range(0, 1));
      t_rs1 = 5'($urandom_range(0, 31));
      t_rs2 = 5'($urandom_range(0, 31));
      t_rd = 5'($urandom_range(0, 31));
      t_rw = 1'($urandom_range(0, 1));
      t_mr = 1'($urandom_range(0, 1));
      t_st = 1'($urandom_range(0, 1));
      t_fl = 1'($urandom_range(0, 1));
      #7;
      check_reset_outputs("reset");
    end
    set_idle();
    model_reset();
    @(negedge clk);
    t_rstn = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back ALU dependency.
    issue(1, 0, 0, 5, 1, 0, 0, 0);
    issue(1, 5, 6, 0, 0, 0, 0, 0);
    check("b2b_a_sel", a_sel, 2'b01);
    check("b2b_b_sel", b_sel, 2'b00);

    // Distance 2.
    issue(1, 0, 0, 7, 1, 0, 0, 0);
    issue(1, 0, 0, 0, 0, 0, 0, 0);
    issue(1, 0, 7, 0, 0, 0, 0, 0);
    check("dist2_b_sel", b_sel, 2'b10);

    // Distance 3.
    issue(1, 0, 0, 7, 1, 0, 0, 0);
    issue(1, 0, 0, 0, 0, 0, 0, 0);
    issue(1, 0, 0, 0, 0, 0, 0, 0);
    issue(1, 7, 0, 0, 0, 0, 0, 0);
    check("dist3_a_sel", a_sel, 2'b11);

    // Two writers of x7: newest wins.
    issue(1, 0, 0, 7, 1, 0, 0, 0);
    issue(1, 0, 0, 7, 1, 0, 0, 0);
    issue(1, 7, 0, 0, 0, 0, 0, 0);
    check("newest_a_sel", a_sel, 2'b01);

    // Load-use: one bubble, then forwarding from MEM/WB.
    issue(1, 0, 0, 9, 1, 1, 0, 0);
    drive(1, 9, 0, 0, 0, 0, 0, 0);
    check("lu_stall", lus, 1'b1);
    step();
    check("lu_cnt", cnt, 16'd1);
    check("lu_bubble_a_sel", a_sel, 2'b00);
    drive(1, 9, 0, 0, 0, 0, 0, 0);
    check("lu_held_stall", lus, 1'b0);
    step();
    check("lu_a_sel", a_sel, 2'b10);

    // x0 never forwards.
    issue(1, 0, 0, 0, 1, 0, 0, 0);
    issue(1, 0, 0, 0, 0, 0, 0, 0);
    check("x0_a_sel", a_sel, 2'b00);
    check("x0_b_sel", b_sel, 2'b00);

    // Flushed writer is a bubble and is not forwarded.
    issue(1, 0, 0, 4, 1, 0, 0, 1);
    issue(1, 4, 0, 0, 0, 0, 0, 0);
    check("flush_a_sel", a_sel, 2'b00);

    // Freeze for 3 cycles in the middle of a load-use.
    issue(1, 0, 0, 9, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 9, 0, 0, 0, 0, 1, 0);
      check("frz_stall", lus, 1'b1);
      step();
      check("frz_cnt", cnt, 16'd1);
      check("frz_a_sel", a_sel, 2'b00);
    end
    drive(1, 9, 0, 0, 0, 0, 0, 0);
    check("frz_resume_stall", lus, 1'b1);
    step();
    check("frz_resume_cnt", cnt, 16'd2);
    issue(1, 9, 0, 0, 0, 0, 0, 0);
    check("frz_resume_a_sel", a_sel, 2'b10);

    // Flush together with load-use: bubble, counter still increments.
    issue(1, 0, 0, 9, 1, 1, 0, 0);
    issue(1, 0, 9, 0, 0, 0, 0, 1);
    check("flush_lu_cnt", cnt, 16'd3);
    check("flush_lu_b_sel", b_sel, 2'b00);
    issue(1, 0, 9, 0, 0, 0, 0, 0);
    check("flush_lu_next_b_sel", b_sel, 2'b10);

    // Asynchronous reset mid-operation with a hazard pending.
    issue(1, 0, 0, 9, 1, 1, 0, 0);
    t_valid = 1'b1; t_rs1 = 5'd9;
    t_rstn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    model_reset();
    set_idle();
    @(negedge clk);
    t_rstn = 1'b1;
    @(posedge clk);
    #1;

    // Five load-use stalls: 2-bit counter saturates at 3.
    for (int i = 0; i < 5; i++) begin
      issue(1, 0, 0, 9, 1, 1, 0, 0);
      issue(1, 9, 0, 0, 0, 0, 0, 0);
      issue(1, 9, 0, 0, 0, 0, 0, 0);
    end
    check("sat_cnt_small", cnt_s, 2'd3);
    check("sat_cnt", cnt, 16'd5);

    // Random streams over a small register range to create many hazards.
    for (int i = 0; i < 600; i++) begin
      issue(1'($urandom_range(0, 9) != 0),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 9) == 0));
    end

    set_idle();
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
